// File: rtl/lsu_bus_demux_if.sv
// Bus bundle between the LSU, the request demux and the two data-side slaves.
// "master" is the LSU plus both slaves seen from outside; "slave" is the demux view.
interface lsu_bus_demux_if #(
    parameter int BUS_WIDTH = 32
);
    logic                 m_valid;
    logic                 m_ready;
    logic [BUS_WIDTH-1:0] m_addr;
    logic [BUS_WIDTH-1:0] m_wdata;
    logic                 m_we;
    logic                 m_rsp_valid;
    logic [BUS_WIDTH-1:0] m_rdata;
    logic                 m_err;
    logic [1:0]           s_valid;
    logic [1:0]           s_ready;
    logic [BUS_WIDTH-1:0] s_addr;
    logic [BUS_WIDTH-1:0] s_wdata;
    logic                 s_we;
    logic [1:0]           s_rsp_valid;
    logic [BUS_WIDTH-1:0] s0_rdata;
    logic [BUS_WIDTH-1:0] s1_rdata;

    modport master (
        output m_valid, m_addr, m_wdata, m_we,
        output s_ready, s_rsp_valid, s0_rdata, s1_rdata,
        input  m_ready, m_rsp_valid, m_rdata, m_err,
        input  s_valid, s_addr, s_wdata, s_we
    );

    modport slave (
        input  m_valid, m_addr, m_wdata, m_we,
        input  s_ready, s_rsp_valid, s0_rdata, s1_rdata,
        output m_ready, m_rsp_valid, m_rdata, m_err,
        output s_valid, s_addr, s_wdata, s_we
    );
endinterface

// File: rtl/lsu_bus_demux.sv
// Single-outstanding request splitter from the LSU to data memory (slave0) and MMIO (slave1),
// with a timeout that converts a hung slave into an error response.
module lsu_bus_demux #(
    parameter int                   BUS_WIDTH = 32,
    parameter logic [BUS_WIDTH-1:0] SLV1_BASE = 32'h8000_0000,
    parameter int                   TIMEOUT   = 15
) (
    input logic            clk,
    input logic            reset,
    lsu_bus_demux_if.slave bus
);
    localparam int            CW       = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
    localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        REQ  = 2'b01,
        WAIT = 2'b10
    } state_t;

    state_t               state_r;
    state_t               state_next_s;
    logic                 ready_r;
    logic                 sel_r;
    logic                 sel_next_s;
    logic [1:0]           s_valid_r;
    logic [BUS_WIDTH-1:0] addr_r;
    logic [BUS_WIDTH-1:0] wdata_r;
    logic                 we_r;
    logic [CW-1:0]        cnt_r;
    logic                 rsp_valid_r;
    logic [BUS_WIDTH-1:0] rdata_r;
    logic                 err_r;

    logic                 accept_s;
    logic                 done_s;
    logic                 abort_s;
    logic                 sel_ready_s;
    logic                 sel_rsp_s;
    logic [BUS_WIDTH-1:0] sel_rdata_s;
    logic                 cnt_last_s;

    assign cnt_last_s = (cnt_r == CNT_LAST);

    // Only the selected slave's handshake and data are ever looked at
    always_comb begin
        sel_ready_s = 1'b0;
        sel_rsp_s   = 1'b0;
        sel_rdata_s = {BUS_WIDTH{1'b0}};
        if (sel_r) begin
            sel_ready_s = bus.s_ready[1];
            sel_rsp_s   = bus.s_rsp_valid[1];
            sel_rdata_s = bus.s1_rdata;
        end else begin
            sel_ready_s = bus.s_ready[0];
            sel_rsp_s   = bus.s_rsp_valid[0];
            sel_rdata_s = bus.s0_rdata;
        end
    end

    // Next-state decode; completion always takes priority over the timeout
    always_comb begin
        state_next_s = state_r;
        sel_next_s   = sel_r;
        accept_s     = 1'b0;
        done_s       = 1'b0;
        abort_s      = 1'b0;
        case (state_r)
            IDLE: begin
                if (bus.m_valid && ready_r) begin
                    accept_s     = 1'b1;
                    sel_next_s   = (bus.m_addr >= SLV1_BASE);
                    state_next_s = REQ;
                end else begin
                    state_next_s = IDLE;
                end
            end
            REQ: begin
                if (sel_ready_s && sel_rsp_s) begin
                    done_s       = 1'b1;
                    state_next_s = IDLE;
                end else if (cnt_last_s) begin
                    abort_s      = 1'b1;
                    state_next_s = IDLE;
                end else if (sel_ready_s) begin
                    state_next_s = WAIT;
                end else begin
                    state_next_s = REQ;
                end
            end
            WAIT: begin
                if (sel_rsp_s) begin
                    done_s       = 1'b1;
                    state_next_s = IDLE;
                end else if (cnt_last_s) begin
                    abort_s      = 1'b1;
                    state_next_s = IDLE;
                end else begin
                    state_next_s = WAIT;
                end
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // State register plus request-side handshake outputs, registered from the next state
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r   <= IDLE;
            ready_r   <= 1'b0;
            sel_r     <= 1'b0;
            s_valid_r <= 2'b00;
        end else begin
            state_r <= state_next_s;
            ready_r <= (state_next_s == IDLE);
            sel_r   <= sel_next_s;
            if (state_next_s == REQ) begin
                s_valid_r <= sel_next_s ? 2'b10 : 2'b01;
            end else begin
                s_valid_r <= 2'b00;
            end
        end
    end

    // Request payload latch and timeout counter
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr_r  <= {BUS_WIDTH{1'b0}};
            wdata_r <= {BUS_WIDTH{1'b0}};
            we_r    <= 1'b0;
            cnt_r   <= {CW{1'b0}};
        end else if (accept_s) begin
            addr_r  <= bus.m_addr;
            wdata_r <= bus.m_wdata;
            we_r    <= bus.m_we;
            cnt_r   <= {CW{1'b0}};
        end else if ((state_r == REQ) || (state_r == WAIT)) begin
            cnt_r <= cnt_r + CNT_ONE;
        end else begin
            cnt_r <= cnt_r;
        end
    end

    // One-cycle response pulse; data and error hold until the next response
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rsp_valid_r <= 1'b0;
            rdata_r     <= {BUS_WIDTH{1'b0}};
            err_r       <= 1'b0;
        end else if (done_s) begin
            rsp_valid_r <= 1'b1;
            rdata_r     <= sel_rdata_s;
            err_r       <= 1'b0;
        end else if (abort_s) begin
            rsp_valid_r <= 1'b1;
            rdata_r     <= {BUS_WIDTH{1'b0}};
            err_r       <= 1'b1;
        end else begin
            rsp_valid_r <= 1'b0;
        end
    end

    assign bus.m_ready     = ready_r;
    assign bus.m_rsp_valid = rsp_valid_r;
    assign bus.m_rdata     = rdata_r;
    assign bus.m_err       = err_r;
    assign bus.s_valid     = s_valid_r;
    assign bus.s_addr      = addr_r;
    assign bus.s_wdata     = wdata_r;
    assign bus.s_we        = we_r;
endmodule

// File: tb/tb_lsu_bus_demux.sv
// Directed self-checking bench for lsu_bus_demux: one task per scenario, cycle-accurate expectations.
module tb_lsu_bus_demux;
    localparam int TIMEOUT = 15;

    logic clk;
    logic reset;
    int   checks;
    int   failures;
    int   rsp_count;

    lsu_bus_demux_if #(.BUS_WIDTH(32)) bus ();

    lsu_bus_demux #(
        .BUS_WIDTH(32),
        .SLV1_BASE(32'h8000_0000),
        .TIMEOUT  (TIMEOUT)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count every response pulse so lost or duplicated responses are visible
    always @(negedge clk) begin
        if (bus.m_rsp_valid === 1'b1) rsp_count <= rsp_count + 1;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.m_valid     = 1'b0;
        bus.m_addr      = 32'h0000_0000;
        bus.m_wdata     = 32'h0000_0000;
        bus.m_we        = 1'b0;
        bus.s_ready     = 2'b00;
        bus.s_rsp_valid = 2'b00;
        bus.s0_rdata    = 32'h0000_0000;
        bus.s1_rdata    = 32'h0000_0000;
    endtask

    task automatic issue(input logic [31:0] addr, input logic [31:0] wdata, input logic we);
        bus.m_valid = 1'b1;
        bus.m_addr  = addr;
        bus.m_wdata = wdata;
        bus.m_we    = we;
        step();
        bus.m_valid = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1'b1;
        step();
        step();
        checks++; if (bus.m_ready !== 1'b0) begin failures++; $display("FAIL rst_m_ready got=%0h exp=0", bus.m_ready); end
        checks++; if (bus.s_valid !== 2'b00) begin failures++; $display("FAIL rst_s_valid got=%0h exp=0", bus.s_valid); end
        checks++; if (bus.m_rsp_valid !== 1'b0) begin failures++; $display("FAIL rst_rsp_valid got=%0h exp=0", bus.m_rsp_valid); end
        checks++; if (bus.m_err !== 1'b0) begin failures++; $display("FAIL rst_m_err got=%0h exp=0", bus.m_err); end
        checks++; if ({bus.m_rdata, bus.s_addr, bus.s_wdata, bus.s_we} !== 97'd0) begin
            failures++; $display("FAIL rst_datapath got=%h/%h/%h/%0h exp=0", bus.m_rdata, bus.s_addr, bus.s_wdata, bus.s_we);
        end
        reset = 1'b0;
        step();
        checks++; if (bus.m_ready !== 1'b1) begin failures++; $display("FAIL rst_release_ready got=%0h exp=1", bus.m_ready); end
    endtask

    task automatic test_store();
        issue(32'h0000_0010, 32'hDEAD_BEEF, 1'b1);
        checks++; if (bus.s_valid !== 2'b01) begin failures++; $display("FAIL t1_s_valid got=%0h exp=1", bus.s_valid); end
        checks++; if (bus.s_we !== 1'b1) begin failures++; $display("FAIL t1_s_we got=%0h exp=1", bus.s_we); end
        checks++; if (bus.s_wdata !== 32'hDEAD_BEEF) begin failures++; $display("FAIL t1_s_wdata got=%h exp=deadbeef", bus.s_wdata); end
        checks++; if (bus.s_addr !== 32'h0000_0010) begin failures++; $display("FAIL t1_s_addr got=%h exp=00000010", bus.s_addr); end
        bus.s_ready = 2'b01;
        step();
        bus.s_ready = 2'b00;
        checks++; if (bus.s_valid !== 2'b00) begin failures++; $display("FAIL t1_wait_s_valid got=%0h exp=0", bus.s_valid); end
        bus.s_rsp_valid = 2'b01;
        bus.s0_rdata    = 32'h5555_0000;
        step();
        bus.s_rsp_valid = 2'b00;
        checks++; if (bus.m_rsp_valid !== 1'b1) begin failures++; $display("FAIL t1_rsp_valid got=%0h exp=1", bus.m_rsp_valid); end
        checks++; if (bus.m_err !== 1'b0) begin failures++; $display("FAIL t1_err got=%0h exp=0", bus.m_err); end
        checks++; if (bus.m_rdata !== 32'h5555_0000) begin failures++; $display("FAIL t1_rdata got=%h exp=55550000", bus.m_rdata); end
        checks++; if (bus.m_ready !== 1'b1) begin failures++; $display("FAIL t1_ready_on_rsp got=%0h exp=1", bus.m_ready); end
        step();
        checks++; if (bus.m_rsp_valid !== 1'b0) begin failures++; $display("FAIL t1_rsp_one_cycle got=%0h exp=0", bus.m_rsp_valid); end
    endtask

    task automatic test_load_stall();
        issue(32'h8000_0004, 32'h0000_0000, 1'b0);
        for (int i = 1; i <= 4; i++) begin
            bus.s_ready = (i == 4) ? 2'b10 : ((i == 2) ? 2'b01 : 2'b00);
            checks++; if (bus.s_valid !== 2'b10) begin failures++; $display("FAIL t2_s_valid_c%0d got=%0h exp=2", i, bus.s_valid); end
            checks++; if ({bus.s_addr, bus.s_we} !== {32'h8000_0004, 1'b0}) begin
                failures++; $display("FAIL t2_payload_c%0d got=%h/%0h exp=80000004/0", i, bus.s_addr, bus.s_we);
            end
            step();
        end
        bus.s_ready     = 2'b00;
        bus.s_rsp_valid = 2'b10;
        bus.s1_rdata    = 32'h1234_5678;
        checks++; if (bus.s_valid !== 2'b00) begin failures++; $display("FAIL t2_wait_s_valid got=%0h exp=0", bus.s_valid); end
        step();
        bus.s_rsp_valid = 2'b00;
        checks++; if (bus.m_rsp_valid !== 1'b1) begin failures++; $display("FAIL t2_rsp_valid got=%0h exp=1", bus.m_rsp_valid); end
        checks++; if (bus.m_rdata !== 32'h1234_5678) begin failures++; $display("FAIL t2_rdata got=%h exp=12345678", bus.m_rdata); end
        step();
    endtask

    task automatic test_timeout();
        issue(32'h0000_0100, 32'h0000_0000, 1'b0);
        for (int i = 1; i <= TIMEOUT; i++) begin
            checks++; if (bus.m_rsp_valid !== 1'b0) begin failures++; $display("FAIL t3_early_rsp_c%0d got=%0h exp=0", i, bus.m_rsp_valid); end
            if (i == TIMEOUT) begin
                checks++; if (bus.s_valid !== 2'b01) begin failures++; $display("FAIL t3_s_valid_last got=%0h exp=1", bus.s_valid); end
            end
            step();
        end
        checks++; if (bus.m_rsp_valid !== 1'b1) begin failures++; $display("FAIL t3_rsp_valid got=%0h exp=1", bus.m_rsp_valid); end
        checks++; if (bus.m_err !== 1'b1) begin failures++; $display("FAIL t3_err got=%0h exp=1", bus.m_err); end
        checks++; if (bus.m_rdata !== 32'h0000_0000) begin failures++; $display("FAIL t3_rdata got=%h exp=0", bus.m_rdata); end
        checks++; if (bus.s_valid !== 2'b00) begin failures++; $display("FAIL t3_s_valid_drop got=%0h exp=0", bus.s_valid); end
        checks++; if (bus.m_ready !== 1'b1) begin failures++; $display("FAIL t3_ready got=%0h exp=1", bus.m_ready); end
        // Exactly at the base address: must go to slave1; ready and response land together
        issue(32'h8000_0000, 32'h0000_0000, 1'b0);
        checks++; if (bus.s_valid !== 2'b10) begin failures++; $display("FAIL t3_base_sel got=%0h exp=2", bus.s_valid); end
        bus.s_ready     = 2'b10;
        bus.s_rsp_valid = 2'b10;
        bus.s1_rdata    = 32'hCAFE_0001;
        step();
        bus.s_ready     = 2'b00;
        bus.s_rsp_valid = 2'b00;
        checks++; if ({bus.m_rsp_valid, bus.m_err} !== 2'b10) begin failures++; $display("FAIL t3_retry_rsp got=%0h exp=2", {bus.m_rsp_valid, bus.m_err}); end
        checks++; if (bus.m_rdata !== 32'hCAFE_0001) begin failures++; $display("FAIL t3_retry_rdata got=%h exp=cafe0001", bus.m_rdata); end
        step();
    endtask

    task automatic test_filter();
        bus.s_rsp_valid = 2'b01;
        bus.s0_rdata    = 32'h0BAD_0BAD;
        step();
        bus.s_rsp_valid = 2'b00;
        checks++; if (bus.m_rsp_valid !== 1'b0) begin failures++; $display("FAIL t4_idle_rsp got=%0h exp=0", bus.m_rsp_valid); end
        issue(32'h7FFF_FFFC, 32'h0000_0000, 1'b0);
        checks++; if (bus.s_valid !== 2'b01) begin failures++; $display("FAIL t4_below_base_sel got=%0h exp=1", bus.s_valid); end
        bus.s_ready = 2'b01;
        step();
        bus.s_ready     = 2'b00;
        bus.s_rsp_valid = 2'b10;
        bus.s1_rdata    = 32'hFFFF_FFFF;
        step();
        bus.s_rsp_valid = 2'b00;
        checks++; if (bus.m_rsp_valid !== 1'b0) begin failures++; $display("FAIL t4_other_slave_rsp got=%0h exp=0", bus.m_rsp_valid); end
        bus.s_rsp_valid = 2'b01;
        bus.s0_rdata    = 32'h0000_00AA;
        step();
        bus.s_rsp_valid = 2'b00;
        checks++; if (bus.m_rsp_valid !== 1'b1) begin failures++; $display("FAIL t4_rsp_valid got=%0h exp=1", bus.m_rsp_valid); end
        checks++; if (bus.m_rdata !== 32'h0000_00AA) begin failures++; $display("FAIL t4_rdata got=%h exp=000000aa", bus.m_rdata); end
        step();
    endtask

    task automatic test_reset_mid();
        issue(32'h0000_0020, 32'h0000_0000, 1'b0);
        bus.s_ready = 2'b01;
        step();
        bus.s_ready = 2'b00;
        reset = 1'b1;
        #1;
        checks++; if (bus.s_valid !== 2'b00) begin failures++; $display("FAIL t5_async_s_valid got=%0h exp=0", bus.s_valid); end
        checks++; if (bus.m_rsp_valid !== 1'b0) begin failures++; $display("FAIL t5_async_rsp got=%0h exp=0", bus.m_rsp_valid); end
        checks++; if (bus.s_addr !== 32'h0000_0000) begin failures++; $display("FAIL t5_async_s_addr got=%h exp=0", bus.s_addr); end
        step();
        reset           = 1'b0;
        bus.s_rsp_valid = 2'b01;
        bus.s0_rdata    = 32'h0000_0999;
        step();
        bus.s_rsp_valid = 2'b00;
        checks++; if (bus.m_rsp_valid !== 1'b0) begin failures++; $display("FAIL t5_late_rsp got=%0h exp=0", bus.m_rsp_valid); end
        checks++; if (bus.m_ready !== 1'b1) begin failures++; $display("FAIL t5_ready got=%0h exp=1", bus.m_ready); end
        issue(32'h0000_0030, 32'h0000_0777, 1'b1);
        checks++; if (bus.s_valid !== 2'b01) begin failures++; $display("FAIL t5_new_s_valid got=%0h exp=1", bus.s_valid); end
        bus.s_ready     = 2'b01;
        bus.s_rsp_valid = 2'b01;
        bus.s0_rdata    = 32'h0000_0777;
        step();
        bus.s_ready     = 2'b00;
        bus.s_rsp_valid = 2'b00;
        checks++; if ({bus.m_rsp_valid, bus.m_err} !== 2'b10) begin failures++; $display("FAIL t5_new_rsp got=%0h exp=2", {bus.m_rsp_valid, bus.m_err}); end
        checks++; if (bus.m_rdata !== 32'h0000_0777) begin failures++; $display("FAIL t5_new_rdata got=%h exp=00000777", bus.m_rdata); end
        step();
    endtask

    task automatic test_back_to_back();
        int base;
        base = rsp_count;
        issue(32'h9000_0000, 32'h0000_0000, 1'b0);
        bus.s_ready = 2'b10;
        step();
        bus.s_ready = 2'b00;
        for (int i = 2; i < TIMEOUT; i++) step();
        checks++; if ({bus.m_rsp_valid, bus.s_valid} !== 3'b000) begin failures++; $display("FAIL t6_last_cycle got=%0h exp=0", {bus.m_rsp_valid, bus.s_valid}); end
        bus.s_rsp_valid = 2'b10;
        bus.s1_rdata    = 32'hBEEF_0015;
        step();
        bus.s_rsp_valid = 2'b00;
        checks++; if ({bus.m_rsp_valid, bus.m_err} !== 2'b10) begin failures++; $display("FAIL t6_edge_rsp got=%0h exp=2", {bus.m_rsp_valid, bus.m_err}); end
        checks++; if (bus.m_rdata !== 32'hBEEF_0015) begin failures++; $display("FAIL t6_edge_rdata got=%h exp=beef0015", bus.m_rdata); end
        issue(32'h0000_0040, 32'h1111_1111, 1'b1);
        checks++; if ({bus.s_valid, bus.s_wdata} !== {2'b01, 32'h1111_1111}) begin
            failures++; $display("FAIL t6_b2b1_req got=%0h/%h exp=1/11111111", bus.s_valid, bus.s_wdata);
        end
        bus.s_ready     = 2'b01;
        bus.s_rsp_valid = 2'b01;
        bus.s0_rdata    = 32'h0000_0041;
        step();
        bus.s_ready     = 2'b00;
        bus.s_rsp_valid = 2'b00;
        checks++; if ({bus.m_rsp_valid, bus.m_rdata} !== {1'b1, 32'h0000_0041}) begin
            failures++; $display("FAIL t6_b2b1_rsp got=%0h/%h exp=1/00000041", bus.m_rsp_valid, bus.m_rdata);
        end
        issue(32'h8000_0100, 32'h0000_0000, 1'b0);
        checks++; if ({bus.s_valid, bus.s_addr} !== {2'b10, 32'h8000_0100}) begin
            failures++; $display("FAIL t6_b2b2_req got=%0h/%h exp=2/80000100", bus.s_valid, bus.s_addr);
        end
        bus.s_ready = 2'b10;
        step();
        bus.s_ready     = 2'b00;
        bus.s_rsp_valid = 2'b10;
        bus.s1_rdata    = 32'h0000_0002;
        step();
        bus.s_rsp_valid = 2'b00;
        checks++; if ({bus.m_rsp_valid, bus.m_rdata} !== {1'b1, 32'h0000_0002}) begin
            failures++; $display("FAIL t6_b2b2_rsp got=%0h/%h exp=1/00000002", bus.m_rsp_valid, bus.m_rdata);
        end
        step();
        checks++; if (bus.m_rsp_valid !== 1'b0) begin failures++; $display("FAIL t6_no_dup got=%0h exp=0", bus.m_rsp_valid); end
        checks++; if ((rsp_count - base) !== 3) begin failures++; $display("FAIL t6_rsp_count got=%0d exp=3", rsp_count - base); end
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        rsp_count = 0;
        reset     = 1'b1;
        idle_inputs();
        test_reset();
        test_store();
        test_load_stall();
        test_timeout();
        test_filter();
        test_reset_mid();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
